apb_master_fsm: RTL and testbench

- Downstream stage of the AXI-to-APB bridge.
- Accepts one decoded transfer request at a time: address, write data, read/write flag and 4-bit transaction ID, as carried by the bridge's APB transaction record.
- Drives the APB SETUP/ACCESS protocol and waits out slave wait states.
- Returns read data, error status and the transaction ID to the AXI response side over a valid/ready handshake.

---
 rtl/apb_master_fsm.sv | 128 ++++++++++++
 tb/tb_apb_master_fsm.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_fsm.sv
// rtl/apb_master_fsm.sv - APB master stage of the AXI-to-APB bridge: one transfer at a time, registered outputs.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_fsm #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic                     req_write,
  input  logic [ID_WIDTH-1:0]      req_id,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [ADDRESS_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0]    pwdata,
  input  logic [DATA_WIDTH-1:0]    prdata,
  input  logic                     pready,
  input  logic                     pslverr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_write,
  output logic [ID_WIDTH-1:0]      rsp_id,
  output logic                     rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_done;
  logic                w_timeout;
  logic [ID_WIDTH-1:0] r_id;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
  end

`ifdef APB_TIMEOUT_EN
  localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [TCNT_W-1:0] r_tcnt;

  // Held at zero outside ACCESS, so it starts from zero on every entry.
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_ACCESS)) begin
      r_tcnt <= '0;
    end else if (!pready) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_ACCESS) && !pready && (r_tcnt == TCNT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_done   = (r_state == ST_ACCESS) && (pready || w_timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (w_done) w_next = ST_RESP;
      ST_RESP:   if (rsp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_write <= 1'b0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      r_id      <= '0;
    end else begin
      req_ready <= (w_next == ST_IDLE);
      psel      <= (w_next == ST_SETUP) || (w_next == ST_ACCESS);
      penable   <= (w_next == ST_ACCESS);
      rsp_valid <= (w_next == ST_RESP);
      if (w_accept) begin
        paddr  <= req_addr;
        pwrite <= req_write;
        pwdata <= req_write ? req_wdata : '0;
        r_id   <= req_id;
      end
      // A pready on the timeout cycle wins, so the slave's status is used.
      if (w_done) begin
        rsp_err   <= pready ? pslverr : 1'b1;
        rsp_rdata <= (pready && !pslverr && !pwrite) ? prdata : '0;
        rsp_write <= pwrite;
        rsp_id    <= r_id;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_fsm.sv
// tb/tb_apb_master_fsm.sv - directed self-checking bench for apb_master_fsm.
module tb_apb_master_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic [3:0]  req_id;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_write;
  logic [3:0]  rsp_id;
  logic        rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  apb_master_fsm #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .ID_WIDTH      (4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_write(req_write),
    .req_id   (req_id),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write),
    .rsp_id   (rsp_id),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] id);
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_write = w;
    req_id    = id;
  endtask

  logic seen_rsp;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_write = 1'b0;
    req_id    = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_req_ready", req_ready, 1);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_paddr", paddr, 0);
    check("rst_rsp_id", rsp_id, 0);

    // Write, zero wait states: accept at N
    pready = 1'b1;
    send(32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 4'd3);
    tick();
    req_valid = 1'b0;
    check("wr_setup_psel", psel, 1);
    check("wr_setup_penable", penable, 0);
    check("wr_setup_req_ready", req_ready, 0);
    check("wr_setup_paddr", paddr, 32'h0000_1004);
    tick();
    check("wr_access_psel", psel, 1);
    check("wr_access_penable", penable, 1);
    check("wr_access_pwrite", pwrite, 1);
    check("wr_access_pwdata", pwdata, 32'hDEAD_BEEF);
    tick();
    check("wr_rsp_valid", rsp_valid, 1);
    check("wr_rsp_psel", psel, 0);
    check("wr_rsp_id", rsp_id, 3);
    check("wr_rsp_err", rsp_err, 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_rsp_write", rsp_write, 1);
    tick();
    check("wr_idle_rsp_valid", rsp_valid, 0);
    check("wr_idle_req_ready", req_ready, 1);
    check("wr_idle_paddr_kept", paddr, 32'h0000_1004);

    // Read with 3 wait states; prdata garbage while pready low must be ignored
    pready = 1'b0;
    prdata = 32'h0BAD_0BAD;
    send(32'h0000_0020, 32'h5555_5555, 1'b0, 4'd5);
    tick();
    req_valid = 1'b0;
    check("rd_setup_pwdata_zero", pwdata, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rd_wait%0d_penable", i), penable, 1);
      check($sformatf("rd_wait%0d_paddr", i), paddr, 32'h20);
      check($sformatf("rd_wait%0d_rsp_valid", i), rsp_valid, 0);
      tick();
    end
    check("rd_access4_penable", penable, 1);
    check("rd_access4_paddr", paddr, 32'h20);
    pready = 1'b1;
    prdata = 32'hCAFE_0001;
    tick();
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
    check("rd_rsp_id", rsp_id, 5);
    check("rd_rsp_write", rsp_write, 0);
    check("rd_rsp_err", rsp_err, 0);
    tick();

    // Slave error on read
    pslverr = 1'b1;
    prdata  = 32'h0000_1234;
    send(32'h0000_0040, 32'h0, 1'b0, 4'd7);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("err_rsp_valid", rsp_valid, 1);
    check("err_rsp_err", rsp_err, 1);
    check("err_rsp_rdata", rsp_rdata, 0);
    check("err_rsp_id", rsp_id, 7);
    pslverr = 1'b0;
    tick();

    // Response backpressure with a second request waiting
    rsp_ready = 1'b0;
    send(32'h0000_0080, 32'h0000_0011, 1'b1, 4'd9);
    tick();
    send(32'h0000_0090, 32'h0, 1'b0, 4'hA);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_rsp_valid", i), rsp_valid, 1);
      check($sformatf("bp%0d_rsp_id", i), rsp_id, 9);
      check($sformatf("bp%0d_rsp_write", i), rsp_write, 1);
      check($sformatf("bp%0d_rsp_err", i), rsp_err, 0);
      check($sformatf("bp%0d_req_ready", i), req_ready, 0);
      check($sformatf("bp%0d_psel", i), psel, 0);
      tick();
    end
    rsp_ready = 1'b1;
    check("bp_hs_rsp_valid", rsp_valid, 1);
    tick();
    check("bp_idle_req_ready", req_ready, 1);
    check("bp_idle_rsp_valid", rsp_valid, 0);
    check("bp_idle_psel", psel, 0);
    tick();
    req_valid = 1'b0;
    check("bp_second_psel", psel, 1);
    check("bp_second_penable", penable, 0);
    check("bp_second_paddr", paddr, 32'h90);
    check("bp_second_pwrite", pwrite, 0);
    prdata = 32'h0000_0077;
    tick();
    tick();
    check("bp_second_rsp_id", rsp_id, 4'hA);
    check("bp_second_rsp_rdata", rsp_rdata, 32'h77);
    tick();

    // Reset while stuck in ACCESS
    pready = 1'b0;
    send(32'h0000_00C0, 32'h0, 1'b0, 4'hC);
    tick();
    req_valid = 1'b0;
    tick();
    check("rstacc_penable", penable, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstacc_psel", psel, 0);
    check("rstacc_penable_low", penable, 0);
    check("rstacc_rsp_valid", rsp_valid, 0);
    check("rstacc_req_ready", req_ready, 1);
    pready   = 1'b1;
    seen_rsp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid) seen_rsp = 1'b1;
    end
    check("rstacc_no_rsp", seen_rsp, 0);

`ifdef APB_TIMEOUT_EN
    pready = 1'b0;
    prdata = 32'h5A5A_5A5A;
    send(32'h0000_00D0, 32'h0, 1'b0, 4'hD);
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_access%0d_penable", i), penable, 1);
      check($sformatf("to_access%0d_rsp_valid", i), rsp_valid, 0);
      tick();
    end
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_rsp_id", rsp_id, 4'hD);
    check("to_psel", psel, 0);
    check("to_penable", penable, 0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
